// File: rtl/scope_capture.sv
// Scales, decimates and triggers paired XADC samples into 640-point waveform RAM frames.
// Optional CAPTURE_PEAK_EN: write the peak of each decimation group instead of its last sample.

module scope_capture #(
   parameter int H_POINTS   = 640,
   parameter int MAX_DIV    = 4,
   parameter int TRIG_LEVEL = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [11:0] s_ch1,
   input  logic [11:0] s_ch2,
   input  logic [2:0]  vdiv1,
   input  logic [2:0]  vdiv2,
   input  logic [2:0]  tdiv,
   input  logic        trig_en,
   input  logic        trig_src,
   output logic [9:0]  wr_addr,
   output logic [8:0]  wr_data1,
   output logic [8:0]  wr_data2,
   output logic        we,
   output logic        armed,
   output logic        frame_done
);

   typedef enum logic {ST_ARM, ST_CAPTURE} state_t;

   localparam logic [9:0] LAST_ADDR   = 10'(H_POINTS - 1);
   localparam logic [8:0] TRIG_THRESH = 9'(256 + TRIG_LEVEL);
   localparam logic [8:0] MIDLINE     = 9'd256;

   function automatic logic [2:0] clampCode(input logic [2:0] code);
      return (code > 3'(MAX_DIV)) ? 3'(MAX_DIV) : code;
   endfunction

   function automatic logic [8:0] scaleSample(input logic [11:0] sample, input logic [2:0] code);
      logic [2:0]         c;
      logic signed [12:0] v;
      c = clampCode(code);
      v = $signed({sample[11], sample});
      // Bias negatives so the arithmetic shift truncates toward zero
      if (sample[11]) v = v + ((13'sd1 <<< c) - 13'sd1);
      v = v >>> c;
      if (v > 13'sd255) v = 13'sd255;
      else if (v < -13'sd255) v = -13'sd255;
      v = v + 13'sd256;
      return v[8:0];
   endfunction

   logic       r_s1Valid;
   logic [8:0] r_s1Ch1, r_s1Ch2;
   logic [2:0] r_decCount;
   logic [8:0] r_prev;
   logic [9:0] r_nextAddr;
   state_t     r_state;

   logic [2:0] w_tdivClamp;
   logic       w_accept;
   logic [8:0] w_grp1, w_grp2, w_trigCur;
   logic       w_trigHit;
   state_t     w_stateNext;
   logic       w_doWrite, w_lastWrite;
   logic [9:0] w_writeAddr, w_nextAddrNext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1Valid <= 1'b0;
         r_s1Ch1   <= MIDLINE;
         r_s1Ch2   <= MIDLINE;
      end else begin
         r_s1Valid <= s_valid;
         if (s_valid) begin
            r_s1Ch1 <= scaleSample(s_ch1, vdiv1);
            r_s1Ch2 <= scaleSample(s_ch2, vdiv2);
         end
      end
   end

   assign w_tdivClamp = clampCode(tdiv);
   assign w_accept    = r_s1Valid && (r_decCount >= w_tdivClamp);

   // A ">=" compare lets a lowered tdiv accept at once instead of waiting for a wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_decCount <= 3'd0;
      else if (r_s1Valid) r_decCount <= w_accept ? 3'd0 : r_decCount + 3'd1;
   end

`ifdef CAPTURE_PEAK_EN
   logic       r_grpOpen;
   logic [8:0] r_peak1, r_peak2;

   assign w_grp1 = (r_grpOpen && (r_peak1 > r_s1Ch1)) ? r_peak1 : r_s1Ch1;
   assign w_grp2 = (r_grpOpen && (r_peak2 > r_s1Ch2)) ? r_peak2 : r_s1Ch2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grpOpen <= 1'b0;
         r_peak1   <= MIDLINE;
         r_peak2   <= MIDLINE;
      end else if (r_s1Valid) begin
         r_grpOpen <= !w_accept;
         r_peak1   <= w_grp1;
         r_peak2   <= w_grp2;
      end
   end
`else
   assign w_grp1 = r_s1Ch1;
   assign w_grp2 = r_s1Ch2;
`endif

   assign w_trigCur = trig_src ? w_grp2 : w_grp1;
   assign w_trigHit = (r_prev < w_trigCur) && (w_trigCur >= TRIG_THRESH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_ARM;
      else      r_state <= w_stateNext;
   end

   // Trigger mode is only consulted at frame wrap, so a started frame always completes
   always_comb begin
      w_stateNext    = r_state;
      w_doWrite      = 1'b0;
      w_lastWrite    = 1'b0;
      w_writeAddr    = r_nextAddr;
      w_nextAddrNext = r_nextAddr;
      case (r_state)
         ST_ARM: begin
            if (w_accept && (!trig_en || w_trigHit)) begin
               w_doWrite      = 1'b1;
               w_writeAddr    = 10'd0;
               w_nextAddrNext = 10'd1;
               w_stateNext    = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (w_accept) begin
               w_doWrite = 1'b1;
               if (r_nextAddr == LAST_ADDR) begin
                  w_lastWrite    = 1'b1;
                  w_nextAddrNext = 10'd0;
                  w_stateNext    = trig_en ? ST_ARM : ST_CAPTURE;
               end else begin
                  w_nextAddrNext = r_nextAddr + 10'd1;
               end
            end
         end
         default: w_stateNext = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nextAddr <= 10'd0;
         r_prev     <= MIDLINE;
         wr_addr    <= 10'd0;
         wr_data1   <= MIDLINE;
         wr_data2   <= MIDLINE;
         we         <= 1'b0;
         armed      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         r_nextAddr <= w_nextAddrNext;
         we         <= w_doWrite;
         frame_done <= w_lastWrite;
         armed      <= (w_stateNext == ST_ARM);
         if (w_accept) r_prev <= w_trigCur;
         if (w_doWrite) begin
            wr_addr  <= w_writeAddr;
            wr_data1 <= w_grp1;
            wr_data2 <= w_grp2;
         end
      end
   end

endmodule
